// File: rtl/lzrw1_compressor.sv
// lzrw1_compressor
//   Byte-serial LZRW1 compressor. Source bytes are gathered into a lookahead
//   buffer. Each item looks up one hash-table candidate and then compares one
//   byte per cycle. Items are packed into a group: a 16-bit control word
//   followed by up to 16 items. The group is sent with the control word
//   first, low byte first.
//
//   Copy items may overlap the bytes being encoded (offset < length). Those
//   bytes are taken from the lookahead buffer instead of from history.
//   Position, history and the hash table persist from one stream to the
//   next. Only reset clears them.
//
// Parameters
//   HASH_BITS : hash-table index width (depth 2^HASH_BITS), at most 12
//   MAX_LEN   : longest copy item / lookahead depth, 3..18
//
// Ports
//   clock          : single clock, posedge
//   reset          : synchronous, active-low
//   valid          : in_byte offered this cycle
//   in_byte[7:0]   : uncompressed source byte
//   last           : with valid, final byte of the stream
//   in_ready       : byte accepted when valid && in_ready
//   comp_byte[7:0] : compressed-stream byte (8'h00 when idle)
//   out_valid      : comp_byte is valid
//   out_ready      : sink accepts comp_byte when out_valid && out_ready
//   finished_cycle : high while the final byte of a group is presented
//   bytes_in/out   : saturating handshake counters, only with LZRW1_COMP_STATS_EN
//
// Handshakes: a transfer happens on the rising clock edge where valid and
// ready are both high. The source side holds its data until that edge. The
// output side holds comp_byte while out_valid && !out_ready.
//
// Optional feature macro: LZRW1_COMP_STATS_EN
module lzrw1_compressor #(
    parameter int HASH_BITS = 12,
    parameter int MAX_LEN   = 18
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       valid,
    input  logic [7:0] in_byte,
    input  logic       last,
    output logic       in_ready,
    output logic [7:0] comp_byte,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       finished_cycle
`ifdef LZRW1_COMP_STATS_EN
    ,
    output logic [31:0] bytes_in,
    output logic [31:0] bytes_out
`endif
);

    typedef enum logic [2:0] {INIT, FILL, HASH, COMPARE, EMIT, FLUSH} state_t;

    state_t state, state_next;

    logic [7:0]           history  [0:4095];
    logic [11:0]          hash_tab [0:(1<<HASH_BITS)-1];
    logic [7:0]           la       [0:MAX_LEN-1];
    logic [7:0]           gbuf     [0:31];

    logic [HASH_BITS-1:0] init_idx;
    logic [4:0]           la_count;
    logic [11:0]          pos;
    logic                 last_seen;
    logic [11:0]          cand;
    logic [11:0]          offset;
    logic [4:0]           k;
    logic                 is_copy;
    logic [4:0]           copy_len;
    logic [4:0]           emit_rem;
    logic                 emit_first;
    logic [5:0]           gcount;
    logic [4:0]           item_count;
    logic [15:0]          ctrl;
    logic [5:0]           fidx;

    logic                 in_fire, out_fire;
    logic [HASH_BITS-1:0] hash_idx;
    logic [11:0]          k_ext;
    logic [7:0]           src_byte;
    logic                 k_more;
    logic                 fin_byte;
    logic [4:0]           items_now;
    logic [3:0]           copy_code;

    assign in_fire  = valid && in_ready;
    assign out_fire = out_valid && out_ready;

    assign hash_idx = HASH_BITS'({la[0], 4'h0} ^ {2'b00, la[1], 2'b00} ^ {4'h0, la[2]});

    // Bytes behind the current position come from history. Bytes at or past
    // it come from the lookahead, so overlapping copies are matched.
    assign k_ext    = {7'b0, k};
    assign src_byte = (k_ext < offset) ? history[cand + k_ext] : la[5'(k_ext - offset)];
    assign k_more   = (k < la_count) && (src_byte == la[k]);

    assign fin_byte  = (fidx == gcount + 6'd1);
    assign items_now = emit_first ? item_count + 5'd1 : item_count;
    assign copy_code = 4'(copy_len - 5'd3);

    always_comb begin
        state_next     = state;
        in_ready       = 1'b0;
        out_valid      = 1'b0;
        finished_cycle = 1'b0;
        comp_byte      = 8'h00;
        case (state)
            INIT:    if (init_idx == '1) state_next = FILL;
            FILL: begin
                in_ready = (la_count < 5'(MAX_LEN)) && !last_seen;
                if (la_count == 5'(MAX_LEN) || last_seen) state_next = HASH;
            end
            HASH:    state_next = (la_count < 5'd3) ? EMIT : COMPARE;
            COMPARE: if (!k_more) state_next = EMIT;
            EMIT: begin
                if (emit_rem == 5'd1) begin
                    if (items_now == 5'd16 || (last_seen && la_count == 5'd1))
                        state_next = FLUSH;
                    else
                        state_next = FILL;
                end
            end
            FLUSH: begin
                out_valid      = 1'b1;
                finished_cycle = fin_byte;
                if (fidx == 6'd0)      comp_byte = ctrl[7:0];
                else if (fidx == 6'd1) comp_byte = ctrl[15:8];
                else                   comp_byte = gbuf[5'(fidx - 6'd2)];
                if (out_ready && fin_byte) state_next = FILL;
            end
            default: state_next = INIT;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= INIT;
            init_idx   <= '0;
            la_count   <= '0;
            pos        <= '0;
            last_seen  <= 1'b0;
            cand       <= '0;
            offset     <= '0;
            k          <= '0;
            is_copy    <= 1'b0;
            copy_len   <= '0;
            emit_rem   <= '0;
            emit_first <= 1'b0;
            gcount     <= '0;
            item_count <= '0;
            ctrl       <= '0;
            fidx       <= '0;
        end else begin
            state <= state_next;
            case (state)
                INIT: init_idx <= init_idx + 1'b1;
                FILL: begin
                    if (in_fire) begin
                        la_count <= la_count + 5'd1;
                        if (last) last_seen <= 1'b1;
                    end
                end
                HASH: begin
                    if (la_count < 5'd3) begin
                        is_copy    <= 1'b0;
                        emit_rem   <= 5'd1;
                        emit_first <= 1'b1;
                    end else begin
                        cand   <= hash_tab[hash_idx];
                        offset <= pos - hash_tab[hash_idx];
                        k      <= '0;
                    end
                end
                COMPARE: begin
                    if (k_more) begin
                        k <= k + 5'd1;
                    end else begin
                        emit_first <= 1'b1;
                        // Offset 0 means the candidate is the current position.
                        if (k >= 5'd3 && offset != 12'd0) begin
                            is_copy  <= 1'b1;
                            copy_len <= k;
                            emit_rem <= k;
                        end else begin
                            is_copy  <= 1'b0;
                            emit_rem <= 5'd1;
                        end
                    end
                end
                EMIT: begin
                    // One consumed byte moves into history per cycle.
                    // The item is appended on the first cycle.
                    emit_first <= 1'b0;
                    pos        <= pos + 12'd1;
                    la_count   <= la_count - 5'd1;
                    emit_rem   <= emit_rem - 5'd1;
                    if (emit_first) begin
                        item_count <= item_count + 5'd1;
                        if (is_copy) begin
                            gcount                <= gcount + 6'd2;
                            ctrl[item_count[3:0]] <= 1'b1;
                        end else begin
                            gcount <= gcount + 6'd1;
                        end
                    end
                end
                FLUSH: begin
                    if (out_fire) begin
                        if (fin_byte) begin
                            fidx       <= '0;
                            gcount     <= '0;
                            item_count <= '0;
                            ctrl       <= '0;
                            if (last_seen && la_count == 5'd0) last_seen <= 1'b0;
                        end else begin
                            fidx <= fidx + 6'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Storage arrays carry no reset. Their contents are qualified by the
    // counters and by the table clear done in INIT.
    always_ff @(posedge clock) begin
        if (reset) begin
            case (state)
                INIT: hash_tab[init_idx] <= '0;
                FILL: if (in_fire) la[la_count] <= in_byte;
                HASH: if (la_count >= 5'd3) hash_tab[hash_idx] <= pos;
                EMIT: begin
                    history[pos] <= la[0];
                    for (int i = 0; i < MAX_LEN - 1; i++) la[i] <= la[i+1];
                    if (emit_first) begin
                        if (is_copy) begin
                            gbuf[gcount[4:0]]        <= {offset[11:8], copy_code};
                            gbuf[gcount[4:0] + 5'd1] <= offset[7:0];
                        end else begin
                            gbuf[gcount[4:0]] <= la[0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef LZRW1_COMP_STATS_EN
    always_ff @(posedge clock) begin
        if (!reset) begin
            bytes_in  <= '0;
            bytes_out <= '0;
        end else begin
            if (in_fire && bytes_in != 32'hFFFF_FFFF)   bytes_in  <= bytes_in + 32'd1;
            if (out_fire && bytes_out != 32'hFFFF_FFFF) bytes_out <= bytes_out + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_lzrw1_compressor.sv
// Directed bench for lzrw1_compressor.
module tb_lzrw1_compressor;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       valid = 1'b0;
  logic [7:0] in_byte = 8'h00;
  logic       last = 1'b0;
  logic       out_ready = 1'b0;
  logic       in_ready;
  logic [7:0] comp_byte;
  logic       out_valid;
  logic       finished_cycle;
`ifdef LZRW1_COMP_STATS_EN
  logic [31:0] bytes_in;
  logic [31:0] bytes_out;
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0] src_q[$];
  logic [7:0] got_q[$];
  logic       fin_q[$];
  logic [7:0] exp_q[$];

  lzrw1_compressor dut (
    .clock          (clock),
    .reset          (reset),
    .valid          (valid),
    .in_byte        (in_byte),
    .last           (last),
    .in_ready       (in_ready),
    .comp_byte      (comp_byte),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .finished_cycle (finished_cycle)
`ifdef LZRW1_COMP_STATS_EN
    ,
    .bytes_in       (bytes_in),
    .bytes_out      (bytes_out)
`endif
  );

  // clock
  always #5 clock = ~clock;

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    int n = 0;
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    while (in_ready !== 1'b1 && n < 5000) begin
      @(negedge clock);
      n++;
    end
    if (n >= 5000) begin
      errors++;
      $display("FAIL reset_wait got in_ready=%b exp 1", in_ready);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic l);
    int n = 0;
    valid   = 1'b1;
    in_byte = b;
    last    = l;
    while (in_ready !== 1'b1 && n < 20000) begin
      @(negedge clock);
      n++;
    end
    if (n >= 20000) begin
      errors++;
      $display("FAIL send_timeout got in_ready=%b exp 1", in_ready);
    end
    @(negedge clock);
    valid = 1'b0;
    last  = 1'b0;
  endtask

  task automatic send_src();
    for (int i = 0; i < src_q.size(); i++)
      send_byte(src_q[i], i == src_q.size() - 1);
  endtask

  task automatic recv_bytes(input int n);
    for (int i = 0; i < n; i++) begin
      int w = 0;
      out_ready = 1'b1;
      while (out_valid !== 1'b1 && w < 20000) begin
        @(negedge clock);
        w++;
      end
      if (w >= 20000) begin
        errors++;
        $display("FAIL recv_timeout got out_valid=%b exp 1", out_valid);
        out_ready = 1'b0;
        return;
      end
      got_q.push_back(comp_byte);
      fin_q.push_back(finished_cycle);
      @(negedge clock);
    end
    out_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int bad = 0;
    reset = 1'b0;
    repeat (3) @(negedge clock);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b exp 0", in_ready); end
    checks++; if (comp_byte !== 8'h00) begin errors++; $display("FAIL rst_comp_byte got %h exp 00", comp_byte); end
    checks++; if (finished_cycle !== 1'b0) begin errors++; $display("FAIL rst_finished got %b exp 0", finished_cycle); end
    reset = 1'b1;
    for (int i = 1; i < 4096; i++) begin
      @(negedge clock);
      if (in_ready !== 1'b0 || out_valid !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL init_busy got %0d busy cycles ready exp 0", bad); end
    @(negedge clock);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL init_done got in_ready=%b exp 1", in_ready); end
  endtask

  task automatic test_abcd();
    got_q.delete(); fin_q.delete();
    src_q = '{8'h41, 8'h42, 8'h43, 8'h44};
    exp_q = '{8'h00, 8'h00, 8'h41, 8'h42, 8'h43, 8'h44};
    send_src();
    recv_bytes(6);
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL abcd_len got %0d exp %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL abcd_byte[%0d] got %h exp %h", i, got_q[i], exp_q[i]); end
      checks++; if (fin_q[i] !== (i == 5)) begin errors++; $display("FAIL abcd_fin[%0d] got %b exp %b", i, fin_q[i], i == 5); end
    end
    repeat (5) @(negedge clock);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL abcd_extra got out_valid=%b exp 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL abcd_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_run_a();
    do_reset();
    got_q.delete(); fin_q.delete(); src_q.delete();
    for (int i = 0; i < 20; i++) src_q.push_back(8'h61);
    exp_q = '{8'h02, 8'h00, 8'h61, 8'h0F, 8'h01, 8'h61};
    send_src();
    recv_bytes(6);
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL run_a_len got %0d exp %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL run_a_byte[%0d] got %h exp %h", i, got_q[i], exp_q[i]); end
      checks++; if (fin_q[i] !== (i == 5)) begin errors++; $display("FAIL run_a_fin[%0d] got %b exp %b", i, fin_q[i], i == 5); end
    end
    repeat (5) @(negedge clock);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL run_a_extra got out_valid=%b exp 0", out_valid); end
  endtask

  task automatic test_distinct();
    do_reset();
    got_q.delete(); fin_q.delete(); src_q.delete(); exp_q.delete();
    for (int i = 0; i < 17; i++) src_q.push_back(8'(i));
    exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    for (int i = 0; i < 16; i++) exp_q.push_back(8'(i));
    exp_q.push_back(8'h00); exp_q.push_back(8'h00); exp_q.push_back(8'h10);
    send_src();
    recv_bytes(21);
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL distinct_len got %0d exp %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL distinct_byte[%0d] got %h exp %h", i, got_q[i], exp_q[i]); end
      checks++; if (fin_q[i] !== (i == 17 || i == 20)) begin errors++; $display("FAIL distinct_fin[%0d] got %b exp %b", i, fin_q[i], i == 17 || i == 20); end
    end
    repeat (5) @(negedge clock);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL distinct_extra got out_valid=%b exp 0", out_valid); end
  endtask

  // "abcabcabc": three literals then a 6-byte copy at offset 3.
  task automatic test_abcabc();
    do_reset();
    got_q.delete(); fin_q.delete();
    src_q = '{8'h61, 8'h62, 8'h63, 8'h61, 8'h62, 8'h63, 8'h61, 8'h62, 8'h63};
    exp_q = '{8'h08, 8'h00, 8'h61, 8'h62, 8'h63, 8'h03, 8'h03};
    send_src();
    recv_bytes(7);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL abcabc_byte[%0d] got %h exp %h", i, got_q[i], exp_q[i]); end
      checks++; if (fin_q[i] !== (i == 6)) begin errors++; $display("FAIL abcabc_fin[%0d] got %b exp %b", i, fin_q[i], i == 6); end
    end
  endtask

  // Two-byte stream: both bytes are literals because the lookahead holds fewer than 3 bytes.
  task automatic test_short();
    got_q.delete(); fin_q.delete();
    src_q = '{8'h41, 8'h42};
    exp_q = '{8'h00, 8'h00, 8'h41, 8'h42};
    send_src();
    recv_bytes(4);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL short_byte[%0d] got %h exp %h", i, got_q[i], exp_q[i]); end
      checks++; if (fin_q[i] !== (i == 3)) begin errors++; $display("FAIL short_fin[%0d] got %b exp %b", i, fin_q[i], i == 3); end
    end
  endtask

  task automatic test_out_ready_stall();
    do_reset();
    got_q.delete(); fin_q.delete(); src_q.delete();
    for (int i = 0; i < 20; i++) src_q.push_back(8'h61);
    exp_q = '{8'h02, 8'h00, 8'h61, 8'h0F, 8'h01, 8'h61};
    send_src();
    recv_bytes(3);
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      checks++; if (out_valid !== 1'b1 || comp_byte !== 8'h0F) begin
        errors++; $display("FAIL stall_hold[%0d] got v=%b %h exp v=1 0f", i, out_valid, comp_byte);
      end
    end
    recv_bytes(3);
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL stall_len got %0d exp %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL stall_byte[%0d] got %h exp %h", i, got_q[i], exp_q[i]); end
      checks++; if (fin_q[i] !== (i == 5)) begin errors++; $display("FAIL stall_fin[%0d] got %b exp %b", i, fin_q[i], i == 5); end
    end
  endtask

  task automatic test_reset_mid_flush();
    int n = 0;
    int leaked = 0;
    do_reset();
    got_q.delete(); fin_q.delete();
    src_q = '{8'h41, 8'h42, 8'h43, 8'h44};
    send_src();
    recv_bytes(2);
    reset = 1'b0;
    @(negedge clock);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got %b exp 0", out_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL midrst_in_ready got %b exp 0", in_ready); end
    checks++; if (comp_byte !== 8'h00) begin errors++; $display("FAIL midrst_comp_byte got %h exp 00", comp_byte); end
    reset = 1'b1;
    while (in_ready !== 1'b1 && n < 5000) begin
      @(negedge clock);
      if (out_valid !== 1'b0) leaked++;
      n++;
    end
    checks++; if (n < 4095 || n >= 5000) begin errors++; $display("FAIL midrst_init_len got %0d cycles exp 4095", n); end
    checks++; if (leaked != 0) begin errors++; $display("FAIL midrst_leak got %0d exp 0", leaked); end
    got_q.delete(); fin_q.delete();
    exp_q = '{8'h00, 8'h00, 8'h41, 8'h42, 8'h43, 8'h44};
    send_src();
    recv_bytes(6);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL midrst_byte[%0d] got %h exp %h", i, got_q[i], exp_q[i]); end
      checks++; if (fin_q[i] !== (i == 5)) begin errors++; $display("FAIL midrst_fin[%0d] got %b exp %b", i, fin_q[i], i == 5); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_abcd();
    test_run_a();
    test_distinct();
    test_abcabc();
    test_short();
    test_out_ready_stall();
    test_reset_mid_flush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
